// File: rtl/rgb_led_pkg.sv
// ---------------------------------------------------------------------------
// rgb_led_pkg
// Shared definitions for the PWM LED array: the global mode encoding and the
// pin-polarity helper used by every channel output register.
// ---------------------------------------------------------------------------
package rgb_led_pkg;

  // Global display mode, matches the 2-bit mode input encoding.
  typedef enum logic [1:0] {
    MODE_STEADY  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  // Map a logical "lit" request onto the physical pin level.
  function automatic logic drive_pin(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/pwm_led_channel.sv
// ---------------------------------------------------------------------------
// pwm_led_channel
// One LED channel: shadow/active duty registers, breathe-envelope scaling,
// PWM comparator and the registered pin driver.
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   load_i       capture level_i into the shadow duty register
//   boundary_i   last cycle of the PWM period; shadow becomes active
//   level_i      requested duty for this channel
//   mode_i       active global mode (already boundary-aligned)
//   blink_on_i   active blink phase (1 = on), boundary-aligned
//   env_i        active breathe envelope value, boundary-aligned
//   cnt_i        shared PWM counter
//   led_o        registered LED pin
// ---------------------------------------------------------------------------
module pwm_led_channel
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_i,
  input  logic                boundary_i,
  input  logic [PWM_BITS-1:0] level_i,
  input  mode_e               mode_i,
  input  logic                blink_on_i,
  input  logic [PWM_BITS-1:0] env_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  output logic                led_o
);

  localparam int PW = 2 * PWM_BITS;

  logic [PWM_BITS-1:0] duty_sh_q, duty_sh_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic                led_q, led_d;
  logic [PW-1:0]       prod_s;
  logic [PWM_BITS-1:0] scaled_s;
  logic [PWM_BITS-1:0] duty_s;

  // level*env + level == level*(env+1): env=MAX reproduces level exactly.
  assign prod_s   = PW'(duty_act_q) * PW'(env_i) + PW'(duty_act_q);
  assign scaled_s = PWM_BITS'(prod_s >> PWM_BITS);

  // Next-state for shadow/active duty and the effective duty for this period.
  always_comb begin
    duty_sh_d  = load_i ? level_i : duty_sh_q;
    // A load on the boundary cycle itself goes straight through to active.
    duty_act_d = boundary_i ? duty_sh_d : duty_act_q;
    case (mode_i)
      MODE_STEADY:  duty_s = duty_act_q;
      MODE_BLINK:   duty_s = blink_on_i ? duty_act_q : '0;
      MODE_BREATHE: duty_s = scaled_s;
      MODE_OFF:     duty_s = '0;
      default:      duty_s = '0;
    endcase
    led_d = drive_pin(cnt_i < duty_s, ACTIVE_LOW);
  end

  // Duty registers and pin register; pin resets to the unlit level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      led_q      <= ACTIVE_LOW;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      led_q      <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/pwm_led_array.sv
// ---------------------------------------------------------------------------
// pwm_led_array
// NUM_CH PWM LED drivers sharing one period counter, with steady / blink /
// breathe / off global modes. Levels and mode are double-buffered and only
// switch at PWM period boundaries so the pins never see a partial period.
// Ports:
//   clk, n_rst     27 MHz clock, asynchronous active-low reset
//   mode           0 steady, 1 blink, 2 breathe, 3 off
//   level          channel i duty at [i*PWM_BITS +: PWM_BITS]
//   load           1-cycle strobe capturing level and mode
//   led            registered LED pins (polarity per ACTIVE_LOW)
//   period_start   registered pulse, high in the cycle after cnt==0
// ---------------------------------------------------------------------------
module pwm_led_array
  import rgb_led_pkg::*;
#(
  parameter int NUM_CH           = 3,
  parameter int PWM_BITS         = 8,
  parameter int BLINK_PERIOD     = 13_500_000,
  parameter int FADE_STEP_CYCLES = 105_000,
  parameter bit ACTIVE_LOW       = 1'b0
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [1:0]                 mode,
  input  logic [NUM_CH*PWM_BITS-1:0] level,
  input  logic                       load,
  output logic [NUM_CH-1:0]          led,
  output logic                       period_start
);

  localparam logic [PWM_BITS-1:0] MAX_V    = PWM_BITS'((2 ** PWM_BITS) - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = MAX_V - PWM_BITS'(1);
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int FW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_STEP_CYCLES - 1);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  mode_e               mode_sh_q, mode_sh_d;
  mode_e               mode_act_q, mode_act_d;
  logic [BW-1:0]       blink_tmr_q, blink_tmr_d;
  logic                blink_ph_q, blink_ph_d;
  logic                blink_app_q, blink_app_d;
  logic [FW-1:0]       fade_tmr_q, fade_tmr_d;
  logic [PWM_BITS-1:0] env_q, env_d;
  logic                env_up_q, env_up_d;
  logic [PWM_BITS-1:0] env_app_q, env_app_d;
  logic                period_start_q, period_start_d;
  logic                boundary_s;
  logic                mode_chg_s;

  assign boundary_s = (cnt_q == CNT_LAST);
  assign mode_chg_s = boundary_s && (mode_sh_d != mode_act_q);

  // Next-state for counter, mode buffers, blink and breathe timers.
  always_comb begin
    cnt_d          = boundary_s ? '0 : cnt_q + PWM_BITS'(1);
    mode_sh_d      = load ? mode_e'(mode) : mode_sh_q;
    mode_act_d     = boundary_s ? mode_sh_d : mode_act_q;
    period_start_d = (cnt_q == '0);

    // Blink timer free-runs only while blink is active; otherwise parked at
    // zero with the phase "on" so entering blink always starts lit.
    blink_tmr_d = '0;
    blink_ph_d  = 1'b1;
    if (mode_chg_s || (mode_act_q != MODE_BLINK)) begin
      blink_tmr_d = '0;
      blink_ph_d  = 1'b1;
    end else if (blink_tmr_q == BLINK_LAST) begin
      blink_tmr_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_tmr_d = blink_tmr_q + BW'(1);
      blink_ph_d  = blink_ph_q;
    end

    // Triangular envelope: direction flips on reaching MAX or 0, so both
    // extremes are held for exactly one step.
    fade_tmr_d = '0;
    env_d      = '0;
    env_up_d   = 1'b1;
    if (mode_chg_s || (mode_act_q != MODE_BREATHE)) begin
      fade_tmr_d = '0;
      env_d      = '0;
      env_up_d   = 1'b1;
    end else if (fade_tmr_q == FADE_LAST) begin
      fade_tmr_d = '0;
      if (env_up_q) begin
        env_d    = env_q + PWM_BITS'(1);
        env_up_d = (env_q != CNT_LAST);
      end else begin
        env_d    = env_q - PWM_BITS'(1);
        env_up_d = (env_q == PWM_BITS'(1));
      end
    end else begin
      fade_tmr_d = fade_tmr_q + FW'(1);
      env_d      = env_q;
      env_up_d   = env_up_q;
    end

    // Phase and envelope reach the channels only at boundaries, so a period
    // is always rendered with one duty value.
    if (mode_chg_s) begin
      blink_app_d = 1'b1;
      env_app_d   = '0;
    end else if (boundary_s) begin
      blink_app_d = blink_ph_q;
      env_app_d   = env_q;
    end else begin
      blink_app_d = blink_app_q;
      env_app_d   = env_app_q;
    end
  end

  // Shared timing state; modes reset to off.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q          <= '0;
      mode_sh_q      <= MODE_OFF;
      mode_act_q     <= MODE_OFF;
      blink_tmr_q    <= '0;
      blink_ph_q     <= 1'b1;
      blink_app_q    <= 1'b1;
      fade_tmr_q     <= '0;
      env_q          <= '0;
      env_up_q       <= 1'b1;
      env_app_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      mode_sh_q      <= mode_sh_d;
      mode_act_q     <= mode_act_d;
      blink_tmr_q    <= blink_tmr_d;
      blink_ph_q     <= blink_ph_d;
      blink_app_q    <= blink_app_d;
      fade_tmr_q     <= fade_tmr_d;
      env_q          <= env_d;
      env_up_q       <= env_up_d;
      env_app_q      <= env_app_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_led_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .n_rst      (n_rst),
      .load_i     (load),
      .boundary_i (boundary_s),
      .level_i    (level[i*PWM_BITS +: PWM_BITS]),
      .mode_i     (mode_act_q),
      .blink_on_i (blink_app_q),
      .env_i      (env_app_q),
      .cnt_i      (cnt_q),
      .led_o      (led[i])
    );
  end

endmodule

// File: tb/tb_pwm_led_array.sv
// ---------------------------------------------------------------------------
// tb_pwm_led_array
// Directed bench: NUM_CH=3, PWM_BITS=4 (period 15), BLINK_PERIOD=100,
// FADE_STEP_CYCLES=2. Two instances share all inputs: one active-high, one
// active-low. Outputs are sampled on the falling clock edge; per-period lit
// counts are taken in windows aligned to period_start.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_led_array;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  mode;
  logic [11:0] level;
  logic        load;
  logic [2:0]  led_h, led_l;
  logic        ps_h, ps_l;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pwm_led_array #(
    .NUM_CH(3), .PWM_BITS(4), .BLINK_PERIOD(100), .FADE_STEP_CYCLES(2), .ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .n_rst(n_rst), .mode(mode), .level(level), .load(load),
    .led(led_h), .period_start(ps_h)
  );

  pwm_led_array #(
    .NUM_CH(3), .PWM_BITS(4), .BLINK_PERIOD(100), .FADE_STEP_CYCLES(2), .ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .n_rst(n_rst), .mode(mode), .level(level), .load(load),
    .led(led_l), .period_start(ps_l)
  );

  task automatic wait_ps();
    int n = 0;
    while (ps_h !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ps_h !== 1'b1) begin
      errors++;
      $display("FAIL wait_ps: period_start=%b after %0d cycles, required 1", ps_h, n);
    end
  endtask

  // 15 samples from the current (period_start) cycle; ends on the next one.
  task automatic count_window(output int r, output int g, output int b,
                              output int rl, output int gl, output int bl,
                              output int psn);
    r = 0; g = 0; b = 0; rl = 0; gl = 0; bl = 0; psn = 0;
    for (int i = 0; i < 15; i++) begin
      r   += (led_h[0] === 1'b1) ? 1 : 0;
      g   += (led_h[1] === 1'b1) ? 1 : 0;
      b   += (led_h[2] === 1'b1) ? 1 : 0;
      rl  += (led_l[0] === 1'b0) ? 1 : 0;
      gl  += (led_l[1] === 1'b0) ? 1 : 0;
      bl  += (led_l[2] === 1'b0) ? 1 : 0;
      psn += (ps_h === 1'b1) ? 1 : 0;
      @(negedge clk);
    end
  endtask

  task automatic load_cfg(input logic [1:0] m, input logic [3:0] r,
                          input logic [3:0] g, input logic [3:0] b);
    mode  = m;
    level = {b, g, r};
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    int lit_h = 0, lit_l = 0, psn = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (led_h !== 3'b000 || led_l !== 3'b111 || ps_h !== 1'b0 || ps_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: led_h=%b led_l=%b ps=%b/%b, required 000 111 0/0",
               led_h, led_l, ps_h, ps_l);
    end
    n_rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lit_h += (led_h !== 3'b000) ? 1 : 0;
      lit_l += (led_l !== 3'b111) ? 1 : 0;
      psn   += (ps_h === 1'b1) ? 1 : 0;
    end
    checks++;
    if (lit_h != 0 || lit_l != 0) begin
      errors++;
      $display("FAIL unlit_before_load: lit cycles h=%0d l=%0d, required 0 0", lit_h, lit_l);
    end
    checks++;
    if (psn != 2) begin
      errors++;
      $display("FAIL ps_after_release: pulses=%0d in 30 cycles, required 2", psn);
    end
  endtask

  task automatic test_steady();
    int r, g, b, rl, gl, bl, psn;
    wait_ps();
    load_cfg(2'd0, 4'd15, 4'd8, 4'd0);
    wait_ps();
    for (int w = 0; w < 2; w++) begin
      count_window(r, g, b, rl, gl, bl, psn);
      checks++;
      if (r != 15 || g != 8 || b != 0) begin
        errors++;
        $display("FAIL steady_high w%0d: r=%0d g=%0d b=%0d, required 15 8 0", w, r, g, b);
      end
      checks++;
      if (rl != 15 || gl != 8 || bl != 0) begin
        errors++;
        $display("FAIL steady_low w%0d: r=%0d g=%0d b=%0d, required 15 8 0", w, rl, gl, bl);
      end
      checks++;
      if (psn != 1) begin
        errors++;
        $display("FAIL ps_per_period w%0d: pulses=%0d, required 1", w, psn);
      end
    end
  endtask

  task automatic test_no_partial();
    int r = 0, g, b, rl, gl, bl, psn;
    for (int i = 0; i < 15; i++) begin
      r += (led_h[0] === 1'b1) ? 1 : 0;
      if (i == 0) begin
        level = {4'd0, 4'd8, 4'd4};
        load  = 1'b1;
      end else if (i == 3) begin
        level = {4'd0, 4'd8, 4'd12};
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (r != 15) begin
      errors++;
      $display("FAIL no_partial_current: r=%0d, required 15", r);
    end
    for (int w = 0; w < 2; w++) begin
      count_window(r, g, b, rl, gl, bl, psn);
      checks++;
      if (r != 12 || g != 8 || rl != 12) begin
        errors++;
        $display("FAIL reload_last_wins w%0d: r=%0d g=%0d rl=%0d, required 12 8 12", w, r, g, rl);
      end
    end
  endtask

  task automatic test_off();
    int r, g, b, rl, gl, bl, psn;
    load_cfg(2'd3, 4'd15, 4'd15, 4'd15);
    wait_ps();
    count_window(r, g, b, rl, gl, bl, psn);
    checks++;
    if (r != 0 || g != 0 || b != 0 || rl != 0 || gl != 0 || bl != 0) begin
      errors++;
      $display("FAIL mode_off: h=%0d/%0d/%0d l=%0d/%0d/%0d, required all 0", r, g, b, rl, gl, bl);
    end
  endtask

  task automatic test_blink();
    int r, g, b, rl, gl, bl, psn, exp;
    load_cfg(2'd1, 4'd15, 4'd0, 4'd0);
    wait_ps();
    for (int p = 0; p < 28; p++) begin
      count_window(r, g, b, rl, gl, bl, psn);
      // Phase flips at 100/200/300 clocks; seen from the following boundary.
      exp = ((p < 7) || (p >= 14 && p < 21) || (p >= 27)) ? 15 : 0;
      checks++;
      if (r != exp || rl != exp) begin
        errors++;
        $display("FAIL blink p%0d: r=%0d rl=%0d, required %0d", p, r, rl, exp);
      end
    end
  endtask

  task automatic test_breathe();
    int r, g, b, rl, gl, bl, psn, s, env, exp_r, exp_g;
    load_cfg(2'd2, 4'd15, 4'd8, 4'd0);
    wait_ps();
    for (int p = 0; p < 8; p++) begin
      count_window(r, g, b, rl, gl, bl, psn);
      // Envelope steps at every 2nd clock after the mode boundary; triangle of 30 steps.
      if (p == 0) begin
        env = 0;
      end else begin
        s   = ((15 * p - 1) / 2) % 30;
        env = (s <= 15) ? s : 30 - s;
      end
      exp_r = (15 * (env + 1)) / 16;
      exp_g = (8 * (env + 1)) / 16;
      checks++;
      if (r != exp_r || g != exp_g || b != 0) begin
        errors++;
        $display("FAIL breathe p%0d env%0d: r=%0d g=%0d b=%0d, required %0d %0d 0",
                 p, env, r, g, b, exp_r, exp_g);
      end
    end
  endtask

  task automatic test_async_reset();
    int r, g, b, rl, gl, bl, psn, bad = 0;
    load_cfg(2'd0, 4'd15, 4'd0, 4'd15);
    wait_ps();
    count_window(r, g, b, rl, gl, bl, psn);
    checks++;
    if (rl != 15 || gl != 0 || bl != 15) begin
      errors++;
      $display("FAIL low_polarity: r=%0d g=%0d b=%0d, required 15 0 15", rl, gl, bl);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (led_h !== 3'b101 || led_l !== 3'b010) begin
      errors++;
      $display("FAIL pre_reset_pins: led_h=%b led_l=%b, required 101 010", led_h, led_l);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (led_h !== 3'b000 || led_l !== 3'b111 || ps_h !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: led_h=%b led_l=%b ps=%b, required 000 111 0", led_h, led_l, ps_h);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bad += (led_h !== 3'b000 || led_l !== 3'b111) ? 1 : 0;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL unlit_after_reset: bad cycles=%0d, required 0", bad);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    mode  = 2'd0;
    level = 12'hFFF;
    load  = 1'b0;
    test_reset();
    test_steady();
    test_no_partial();
    test_off();
    test_blink();
    test_breathe();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
